mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Consumer of the execute stage outputs (ALU result, store data, branch target, zero flag). Sits in the MEM position of the 64-bit LEGv8 pipeline.
- Resolves the conditional-branch decision (PCSrc).
- Runs a multi-cycle request/ready handshake with data memory for LDUR/STUR, stalling the pipeline while the access is outstanding.
- Registers the MEM/WB results for the writeback stage.

Parameters:
- N, 64: datapath width. Address, store data, load data and ALU result are all N bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- valid_M  in  1  an instruction is present in MEM
- memRead_M  in  1  instruction is a load
- memWrite_M  in  1  instruction is a store
- Branch_M  in  1  instruction is a CBZ-type branch
- aluResult_M  in  N  effective address, or ALU result
- writeData_M  in  N  store data
- zero_M  in  1  ALU zero flag
- PCBranch_M  in  N  branch target
- dm_req  out  1  data-memory request
- dm_we  out  1  1 = write, 0 = read
- dm_addr  out  N  byte address; low 3 bits are always 0
- dm_wdata  out  N  store data
- dm_ready  in  1  memory completes the request this cycle
- dm_rdata  in  N  load data, valid when dm_ready=1 and dm_we=0
- PCSrc_M  out  1  take the branch
- PCBranch_out  out  N  PCBranch_M passed through unchanged
- stall_M  out  1  freeze IF/ID/EX and the EX/MEM register
- misalign_M  out  1  one-cycle pulse: a memory op was rejected
- valid_W  out  1  MEM/WB holds a valid instruction
- readData_W  out  N  registered load data
- aluResult_W  out  N  registered ALU result

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; dm_req, dm_we, valid_W, misalign_M = 0; dm_addr, dm_wdata, readData_W, aluResult_W = 0.
  - An outstanding request is abandoned: dm_req drops immediately, and a dm_ready arriving after reset releases is ignored.
- memop = valid_M & (memRead_M | memWrite_M).
- If memRead_M and memWrite_M are both 1, the op is treated as a store.
- Misaligned: aluResult_M[2:0] != 0.
- PCSrc_M = valid_M & Branch_M & zero_M. It is combinational and independent of FSM state.
- FSM states: IDLE, ACCESS.
  - IDLE, memop and aligned:
    - latch dm_addr=aluResult_M, dm_wdata=writeData_M, dm_we=memWrite_M; set dm_req=1 next cycle.
    - go to ACCESS.
    - stall_M=1 combinationally this cycle.
  - IDLE, memop and misaligned:
    - no request is issued.
    - misalign_M=1 next cycle for exactly one cycle.
    - instruction retires to WB with readData_W=0; no stall.
  - IDLE, no memop: stall_M=0; MEM/WB loads next cycle (latency 1).
  - ACCESS:
    - dm_req, dm_we, dm_addr and dm_wdata hold stable until dm_ready.
    - stall_M = ~dm_ready.
    - On dm_ready: readData_W ← dm_rdata for a load, or unchanged for a store; aluResult_W ← dm_addr; valid_W ← 1; dm_req ← 0; go to IDLE.
    - The next op is accepted no earlier than the cycle after return to IDLE. Back-to-back accesses therefore have at least one idle dm_req cycle.
- dm_ready while dm_req=0 is ignored.
- MEM/WB register:
  - loads when stall_M=0, from aluResult_M, valid_M and (for misaligned loads) 0.
  - while stall_M=1: valid_W ← 0 (bubble into WB); readData_W and aluResult_W hold.
- dm_ready may arrive in the first ACCESS cycle, giving total memory-op latency 2 cycles; there is no upper bound on wait.

Decomposition:
- Shared package mem_stage_pkg:
  - typedef enum logic {IDLE, ACCESS} mem_state_t
  - constant WORD_ALIGN_BITS = 3
- One sub-module: mem_wb_reg (N-bit enable register with async active-low reset).
  - Instantiated for readData_W, aluResult_W and valid_W.
  - The FSM and handshake stay in mem_access_stage.

Test Plan:
- Reset mid-access:
  - issue a load at 0x40, then pull reset=0 during the wait → dm_req, stall_M, valid_W are 0 immediately.
  - after release, a late dm_ready=1 has no effect and state is IDLE.
- ALU op (valid_M=1, aluResult_M=0x1234, no memop) → next cycle valid_W=1, aluResult_W=0x1234, stall_M=0 throughout, dm_req never 1.
- Load at aluResult_M=0x100, memory ready after 3 wait cycles with dm_rdata=0xDEADBEEF:
  - dm_req=1, dm_we=0, dm_addr=0x100 held stable.
  - stall_M=1 for 4 cycles.
  - then readData_W=0xDEADBEEF, valid_W=1.
- Store at 0x208 with writeData_M=0xCAFE, dm_ready in the first ACCESS cycle → dm_we=1, dm_wdata=0xCAFE, stall_M=1 for exactly 1 cycle; memop latency 2.
- Misaligned load at 0x103 → no dm_req, misalign_M=1 for exactly 1 cycle, valid_W=1, readData_W=0.
- Branch with Branch_M=1, zero_M=1, PCBranch_M=0x400:
  - PCSrc_M=1 in the same cycle and PCBranch_out=0x400.
  - with zero_M=0 → PCSrc_M=0.
  - with valid_M=0 → PCSrc_M=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the LEGv8 MEM stage.
package mem_stage_pkg;
    typedef enum logic {IDLE, ACCESS} mem_state_t;
    localparam int WORD_ALIGN_BITS = 3;
endpackage

// File: rtl/mem_wb_reg.sv
// N-bit enable register with asynchronous active-low reset, used for the MEM/WB fields.
module mem_wb_reg #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (en)
            q <= d;
    end
endmodule

// File: rtl/mem_access_stage.sv
// LEGv8 MEM stage: branch resolution, data-memory request/ready handshake
// with pipeline stall, and the MEM/WB result register.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_M,
    input  logic         memRead_M,
    input  logic         memWrite_M,
    input  logic         Branch_M,
    input  logic [N-1:0] aluResult_M,
    input  logic [N-1:0] writeData_M,
    input  logic         zero_M,
    input  logic [N-1:0] PCBranch_M,
    output logic         dm_req,
    output logic         dm_we,
    output logic [N-1:0] dm_addr,
    output logic [N-1:0] dm_wdata,
    input  logic         dm_ready,
    input  logic [N-1:0] dm_rdata,
    output logic         PCSrc_M,
    output logic [N-1:0] PCBranch_out,
    output logic         stall_M,
    output logic         misalign_M,
    output logic         valid_W,
    output logic [N-1:0] readData_W,
    output logic [N-1:0] aluResult_W
);
    mem_state_t   state_q, state_d;
    logic         dm_req_q, dm_req_d;
    logic         dm_we_q, dm_we_d;
    logic [N-1:0] dm_addr_q, dm_addr_d;
    logic [N-1:0] dm_wdata_q, dm_wdata_d;
    logic         misalign_q, misalign_d;

    logic         memop, misaligned, stall_c;
    logic         wb_alu_en, wb_rd_en, wb_vld_d;
    logic [N-1:0] wb_alu_d, wb_rd_d;

    assign memop      = valid_M & (memRead_M | memWrite_M);
    assign misaligned = |aluResult_M[WORD_ALIGN_BITS-1:0];

    assign PCSrc_M      = valid_M & Branch_M & zero_M;
    assign PCBranch_out = PCBranch_M;

    always_comb begin
        state_d    = state_q;
        dm_req_d   = dm_req_q;
        dm_we_d    = dm_we_q;
        dm_addr_d  = dm_addr_q;
        dm_wdata_d = dm_wdata_q;
        misalign_d = 1'b0;
        stall_c    = 1'b0;
        wb_alu_en  = 1'b0;
        wb_alu_d   = aluResult_M;
        wb_rd_en   = 1'b0;
        wb_rd_d    = '0;
        wb_vld_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (memop && !misaligned) begin
                    dm_req_d   = 1'b1;
                    dm_we_d    = memWrite_M;
                    dm_addr_d  = aluResult_M;
                    dm_wdata_d = writeData_M;
                    state_d    = ACCESS;
                    stall_c    = 1'b1;
                end else begin
                    // Rejected memory ops retire immediately with zero load data.
                    misalign_d = memop;
                    wb_alu_en  = 1'b1;
                    wb_vld_d   = valid_M;
                    wb_rd_en   = memop;
                end
            end
            ACCESS: begin
                stall_c = ~dm_ready;
                if (dm_ready) begin
                    dm_req_d  = 1'b0;
                    state_d   = IDLE;
                    wb_alu_en = 1'b1;
                    wb_alu_d  = dm_addr_q;
                    wb_vld_d  = 1'b1;
                    wb_rd_en  = ~dm_we_q;
                    wb_rd_d   = dm_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Nothing is held up while reset is asserted, even if an op sits in MEM.
    assign stall_M = stall_c & reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_wdata_q <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dm_req_q   <= dm_req_d;
            dm_we_q    <= dm_we_d;
            dm_addr_q  <= dm_addr_d;
            dm_wdata_q <= dm_wdata_d;
            misalign_q <= misalign_d;
        end
    end

    assign dm_req     = dm_req_q;
    assign dm_we      = dm_we_q;
    assign dm_addr    = dm_addr_q;
    assign dm_wdata   = dm_wdata_q;
    assign misalign_M = misalign_q;

    mem_wb_reg #(.N(N)) u_wb_rdata (
        .clk(clk), .rst_n(reset), .en(wb_rd_en), .d(wb_rd_d), .q(readData_W)
    );

    mem_wb_reg #(.N(N)) u_wb_alu (
        .clk(clk), .rst_n(reset), .en(wb_alu_en), .d(wb_alu_d), .q(aluResult_W)
    );

    mem_wb_reg #(.N(1)) u_wb_valid (
        .clk(clk), .rst_n(reset), .en(1'b1), .d(wb_vld_d), .q(valid_W)
    );
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, load/store handshake,
// misaligned rejection, branch decision and reset during an outstanding access.
module tb_mem_access_stage;
    localparam int N = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid_M, memRead_M, memWrite_M, Branch_M, zero_M;
    logic [N-1:0] aluResult_M, writeData_M, PCBranch_M;
    logic         dm_req, dm_we, dm_ready;
    logic [N-1:0] dm_addr, dm_wdata, dm_rdata;
    logic         PCSrc_M, stall_M, misalign_M, valid_W;
    logic [N-1:0] PCBranch_out, readData_W, aluResult_W;

    int errors = 0;
    int checks = 0;
    int stall_cnt;

    always #5 clk = ~clk;

    mem_access_stage #(.N(N)) dut (
        .clk(clk), .reset(reset),
        .valid_M(valid_M), .memRead_M(memRead_M), .memWrite_M(memWrite_M),
        .Branch_M(Branch_M), .aluResult_M(aluResult_M), .writeData_M(writeData_M),
        .zero_M(zero_M), .PCBranch_M(PCBranch_M),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .PCSrc_M(PCSrc_M), .PCBranch_out(PCBranch_out), .stall_M(stall_M),
        .misalign_M(misalign_M), .valid_W(valid_W),
        .readData_W(readData_W), .aluResult_W(aluResult_W)
    );

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        valid_M = 0; memRead_M = 0; memWrite_M = 0; Branch_M = 0; zero_M = 0;
        aluResult_M = '0; writeData_M = '0; PCBranch_M = '0;
        dm_ready = 0; dm_rdata = '0;
    endtask

    initial begin
        clear_in();
        reset = 0;
        #2;
        chk("rst_dm_req", {63'd0, dm_req}, 64'd0);
        chk("rst_valid_W", {63'd0, valid_W}, 64'd0);
        chk("rst_misalign", {63'd0, misalign_M}, 64'd0);
        chk("rst_readData_W", readData_W, 64'd0);
        chk("rst_aluResult_W", aluResult_W, 64'd0);
        chk("rst_dm_addr", dm_addr, 64'd0);
        step();
        reset = 1;

        // ALU op passes straight through with latency 1
        step();
        valid_M = 1; aluResult_M = 64'h1234;
        @(negedge clk);
        chk("alu_stall", {63'd0, stall_M}, 64'd0);
        chk("alu_req", {63'd0, dm_req}, 64'd0);
        step();
        clear_in();
        @(negedge clk);
        chk("alu_valid_W", {63'd0, valid_W}, 64'd1);
        chk("alu_aluResult_W", aluResult_W, 64'h1234);
        chk("alu_req2", {63'd0, dm_req}, 64'd0);

        // Load at 0x100, three wait cycles before ready
        step();
        valid_M = 1; memRead_M = 1; aluResult_M = 64'h100;
        stall_cnt = 0;
        @(negedge clk);
        chk("ld_issue_req", {63'd0, dm_req}, 64'd0);
        if (stall_M) stall_cnt++;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("ld_wait_req", {63'd0, dm_req}, 64'd1);
            chk("ld_wait_we", {63'd0, dm_we}, 64'd0);
            chk("ld_wait_addr", dm_addr, 64'h100);
            chk("ld_wait_valid_W", {63'd0, valid_W}, 64'd0);
            if (stall_M) stall_cnt++;
        end
        step();
        dm_ready = 1; dm_rdata = 64'hDEADBEEF;
        @(negedge clk);
        chk("ld_ready_stall", {63'd0, stall_M}, 64'd0);
        chk("ld_ready_addr", dm_addr, 64'h100);
        chk("ld_stall_cycles", 64'(stall_cnt), 64'd4);
        step();
        clear_in();
        @(negedge clk);
        chk("ld_valid_W", {63'd0, valid_W}, 64'd1);
        chk("ld_readData_W", readData_W, 64'hDEADBEEF);
        chk("ld_aluResult_W", aluResult_W, 64'h100);
        chk("ld_req_drop", {63'd0, dm_req}, 64'd0);

        // Store at 0x208, ready in the first ACCESS cycle
        step();
        valid_M = 1; memWrite_M = 1; aluResult_M = 64'h208; writeData_M = 64'hCAFE;
        @(negedge clk);
        chk("st_issue_stall", {63'd0, stall_M}, 64'd1);
        step();
        dm_ready = 1;
        @(negedge clk);
        chk("st_req", {63'd0, dm_req}, 64'd1);
        chk("st_we", {63'd0, dm_we}, 64'd1);
        chk("st_wdata", dm_wdata, 64'hCAFE);
        chk("st_addr", dm_addr, 64'h208);
        chk("st_stall", {63'd0, stall_M}, 64'd0);
        step();
        clear_in();
        @(negedge clk);
        chk("st_valid_W", {63'd0, valid_W}, 64'd1);
        chk("st_aluResult_W", aluResult_W, 64'h208);
        chk("st_readData_hold", readData_W, 64'hDEADBEEF);
        chk("st_req_drop", {63'd0, dm_req}, 64'd0);

        // Misaligned load at 0x103 is rejected
        step();
        valid_M = 1; memRead_M = 1; aluResult_M = 64'h103;
        @(negedge clk);
        chk("mis_stall", {63'd0, stall_M}, 64'd0);
        chk("mis_flag0", {63'd0, misalign_M}, 64'd0);
        step();
        clear_in();
        @(negedge clk);
        chk("mis_flag", {63'd0, misalign_M}, 64'd1);
        chk("mis_req", {63'd0, dm_req}, 64'd0);
        chk("mis_valid_W", {63'd0, valid_W}, 64'd1);
        chk("mis_readData_W", readData_W, 64'd0);
        chk("mis_aluResult_W", aluResult_W, 64'h103);
        step();
        @(negedge clk);
        chk("mis_flag_pulse", {63'd0, misalign_M}, 64'd0);

        // Branch decision is purely combinational
        step();
        valid_M = 1; Branch_M = 1; zero_M = 1; PCBranch_M = 64'h400;
        #1;
        chk("br_taken", {63'd0, PCSrc_M}, 64'd1);
        chk("br_target", PCBranch_out, 64'h400);
        zero_M = 0;
        #1;
        chk("br_nz", {63'd0, PCSrc_M}, 64'd0);
        zero_M = 1; valid_M = 0;
        #1;
        chk("br_invalid", {63'd0, PCSrc_M}, 64'd0);

        // Reset while a load at 0x40 is outstanding
        step();
        clear_in();
        valid_M = 1; memRead_M = 1; aluResult_M = 64'h40;
        step();
        @(negedge clk);
        chk("rma_req", {63'd0, dm_req}, 64'd1);
        #1;
        reset = 0;
        #1;
        chk("rma_req_drop", {63'd0, dm_req}, 64'd0);
        chk("rma_stall", {63'd0, stall_M}, 64'd0);
        chk("rma_valid_W", {63'd0, valid_W}, 64'd0);
        step();
        clear_in();
        reset = 1;
        dm_ready = 1; dm_rdata = 64'h5555;
        @(negedge clk);
        chk("rma_late_req", {63'd0, dm_req}, 64'd0);
        chk("rma_late_stall", {63'd0, stall_M}, 64'd0);
        step();
        dm_ready = 0;
        @(negedge clk);
        chk("rma_late_valid_W", {63'd0, valid_W}, 64'd0);
        chk("rma_late_readData", readData_W, 64'd0);
        // An ALU op now flows through, showing the FSM is back in IDLE
        step();
        valid_M = 1; aluResult_M = 64'h77;
        @(negedge clk);
        chk("rma_idle_stall", {63'd0, stall_M}, 64'd0);
        step();
        clear_in();
        @(negedge clk);
        chk("rma_idle_valid_W", {63'd0, valid_W}, 64'd1);
        chk("rma_idle_alu_W", aluResult_W, 64'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
